// File: rtl/serdes_pkg.sv
// Shared SERDES definitions: word width, default control words, FSM states and
// the forward per-byte bit permutation that the receive reorder undoes.
package serdes_pkg;

  localparam int WORD_W = 32;

  localparam logic [WORD_W-1:0] TRAIN_WORD_DEF = 32'hBCBC_BCBC;
  localparam logic [WORD_W-1:0] SYNC_WORD_DEF  = 32'hA5A5_5A5A;
  localparam logic [WORD_W-1:0] IDLE_WORD_DEF  = 32'hF0F0_F0F0;

  typedef enum logic {
    ST_TRAIN = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  // Even input bits land on the upper nibble, odd bits on the lower nibble, both reversed.
  function automatic logic [WORD_W-1:0] fwd_map32(input logic [WORD_W-1:0] w);
    logic [WORD_W-1:0] m;
    m = '0;
    for (int b = 0; b < WORD_W / 8; b++) begin
      m[8*b+7] = w[8*b+0];
      m[8*b+6] = w[8*b+2];
      m[8*b+5] = w[8*b+4];
      m[8*b+4] = w[8*b+6];
      m[8*b+3] = w[8*b+1];
      m[8*b+2] = w[8*b+3];
      m[8*b+1] = w[8*b+5];
      m[8*b+0] = w[8*b+7];
    end
    return m;
  endfunction

endpackage

// File: rtl/tx_skid_fifo2.sv
// Two-entry payload buffer in front of the framer; simultaneous push and pop
// keep the occupancy unchanged, and reset discards the contents immediately.
module tx_skid_fifo2
  import serdes_pkg::*;
#(
  parameter int W = WORD_W
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic [W-1:0] head_o,
  output logic [1:0]   count_o
);

  logic [W-1:0] mem_q [0:1];
  logic         wr_ptr_q;
  logic         rd_ptr_q;
  logic [1:0]   count_q;
  logic [1:0]   count_d;
  logic         push_ok;
  logic         pop_ok;

  assign push_ok = push_i && (count_q != 2'd2);
  assign pop_ok  = pop_i && (count_q != 2'd0);

  always_comb begin
    count_d = count_q;
    if (push_ok && !pop_ok) begin
      count_d = count_q + 2'd1;
    end else if (!push_ok && pop_ok) begin
      count_d = count_q - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_ok) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_d;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/tx_map_framer.sv
// SERDES TX framer: training after reset, then payload with periodic sync and idle fill,
// all bit-mapped. Define TX_MAP_PRBS_EN to add the prbs_mode port and PRBS-7 payload source.
module tx_map_framer
  import serdes_pkg::*;
#(
  parameter int                TRAIN_LEN   = 16,
  parameter int                SYNC_PERIOD = 256,
  parameter logic [WORD_W-1:0] TRAIN_WORD  = TRAIN_WORD_DEF,
  parameter logic [WORD_W-1:0] SYNC_WORD   = SYNC_WORD_DEF,
  parameter logic [WORD_W-1:0] IDLE_WORD   = IDLE_WORD_DEF
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [WORD_W-1:0] tx_data,
  output logic              tx_ctrl,
`ifdef TX_MAP_PRBS_EN
  input  logic              prbs_mode,
`endif
  output logic              tx_train
);

  localparam int TCW = (TRAIN_LEN > 1) ? $clog2(TRAIN_LEN) : 1;
  localparam int SCW = $clog2(SYNC_PERIOD);
  localparam logic [TCW-1:0] TRAIN_LAST = TCW'(TRAIN_LEN - 1);
  localparam logic [SCW-1:0] SYNC_LAST  = SCW'(SYNC_PERIOD - 1);

  state_e            state_q,     state_d;
  logic [TCW-1:0]    train_cnt_q, train_cnt_d;
  logic [SCW-1:0]    sync_cnt_q,  sync_cnt_d;
  logic [WORD_W-1:0] tx_data_q,   tx_data_d;
  logic              tx_ctrl_q,   tx_ctrl_d;
  logic              tx_train_q,  tx_train_d;

  logic [WORD_W-1:0] slot_word;
  logic              next_is_run;
  logic              fifo_push;
  logic              fifo_pop;
  logic [WORD_W-1:0] fifo_head;
  logic [1:0]        fifo_count;
  logic              prbs_active;

`ifdef TX_MAP_PRBS_EN
  localparam logic [6:0] PRBS_SEED = 7'h7F;

  logic [6:0]        prbs_q, prbs_d;
  logic [6:0]        prbs_adv_state;
  logic [WORD_W-1:0] prbs_adv_word;

  // x^7+x^6+1, 32 steps per word; the first generated bit becomes bit 31.
  function automatic logic [38:0] prbs7_advance32(input logic [6:0] seed);
    logic [6:0]  s;
    logic [31:0] w;
    logic        fb;
    s = seed;
    w = '0;
    for (int i = 0; i < 32; i++) begin
      fb        = s[6] ^ s[5];
      w[31 - i] = fb;
      s         = {s[5:0], fb};
    end
    return {s, w};
  endfunction

  assign {prbs_adv_state, prbs_adv_word} = prbs7_advance32(prbs_q);
  assign prbs_active = prbs_mode;
`else
  assign prbs_active = 1'b0;
`endif

  assign in_ready  = (state_q == ST_RUN) && (fifo_count != 2'd2) && !prbs_active;
  assign fifo_push = in_valid && in_ready;

  tx_skid_fifo2 #(
    .W(WORD_W)
  ) u_fifo (
    .clk    (clk),
    .rstn   (rstn),
    .push_i (fifo_push),
    .data_i (in_data),
    .pop_i  (fifo_pop),
    .head_o (fifo_head),
    .count_o(fifo_count)
  );

  // Everything below decides the word for the next output slot.
  always_comb begin
    state_d     = state_q;
    train_cnt_d = train_cnt_q;
    sync_cnt_d  = sync_cnt_q;
    tx_ctrl_d   = 1'b1;
    tx_train_d  = 1'b0;
    slot_word   = IDLE_WORD;
    fifo_pop    = 1'b0;
    next_is_run = 1'b0;
`ifdef TX_MAP_PRBS_EN
    prbs_d      = prbs_q;
`endif

    case (state_q)
      ST_TRAIN: begin
        if (train_cnt_q == TRAIN_LAST) begin
          state_d     = ST_RUN;
          train_cnt_d = '0;
          sync_cnt_d  = '0;
          next_is_run = 1'b1;
        end else begin
          train_cnt_d = train_cnt_q + 1'b1;
        end
      end
      ST_RUN: begin
        sync_cnt_d  = (sync_cnt_q == SYNC_LAST) ? '0 : sync_cnt_q + 1'b1;
        next_is_run = 1'b1;
      end
      default: begin
        state_d = ST_TRAIN;
      end
    endcase

    if (!next_is_run) begin
      slot_word  = TRAIN_WORD;
      tx_train_d = 1'b1;
    end else if (sync_cnt_d == SYNC_LAST) begin
      slot_word = SYNC_WORD;
`ifdef TX_MAP_PRBS_EN
    end else if (prbs_active) begin
      slot_word = prbs_adv_word;
      tx_ctrl_d = 1'b0;
      prbs_d    = prbs_adv_state;
`endif
    end else if (fifo_count != 2'd0) begin
      slot_word = fifo_head;
      tx_ctrl_d = 1'b0;
      fifo_pop  = 1'b1;
    end

    tx_data_d = fwd_map32(slot_word);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_TRAIN;
      train_cnt_q <= '0;
      sync_cnt_q  <= '0;
      tx_data_q   <= fwd_map32(TRAIN_WORD);
      tx_ctrl_q   <= 1'b1;
      tx_train_q  <= 1'b1;
`ifdef TX_MAP_PRBS_EN
      prbs_q      <= PRBS_SEED;
`endif
    end else begin
      state_q     <= state_d;
      train_cnt_q <= train_cnt_d;
      sync_cnt_q  <= sync_cnt_d;
      tx_data_q   <= tx_data_d;
      tx_ctrl_q   <= tx_ctrl_d;
      tx_train_q  <= tx_train_d;
`ifdef TX_MAP_PRBS_EN
      prbs_q      <= prbs_d;
`endif
    end
  end

  assign tx_data  = tx_data_q;
  assign tx_ctrl  = tx_ctrl_q;
  assign tx_train = tx_train_q;

endmodule

// File: tb/tb_tx_map_framer.sv
// Directed bench for tx_map_framer with TRAIN_LEN=4, SYNC_PERIOD=8; the PRBS
// section is compiled only when TX_MAP_PRBS_EN is defined.
module tb_tx_map_framer;

  localparam logic [31:0] TRAIN_M = 32'h6767_6767;
  localparam logic [31:0] SYNC_M  = 32'hC3C3_3C3C;
  localparam logic [31:0] IDLE_M  = 32'h3333_3333;

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] tx_data;
  logic        tx_ctrl;
  logic        tx_train;
`ifdef TX_MAP_PRBS_EN
  logic        prbs_mode;
  logic [6:0]  refLfsr;
  logic [31:0] refWord;
`endif

  int          checks = 0;
  int          errors = 0;
  int          slot;
  logic [31:0] nextData;
  logic [31:0] expPayload;
  logic        accepted;

  tx_map_framer #(
    .TRAIN_LEN  (4),
    .SYNC_PERIOD(8)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .tx_data  (tx_data),
    .tx_ctrl  (tx_ctrl),
`ifdef TX_MAP_PRBS_EN
    .prbs_mode(prbs_mode),
`endif
    .tx_train (tx_train)
  );

  always #5 clk = ~clk;

  // Receive-side reorder: undoes the transmit permutation byte by byte.
  function automatic logic [31:0] rxReorder(input logic [31:0] w);
    logic [31:0] r;
    r = '0;
    for (int b = 0; b < 4; b++) begin
      r[8*b+0] = w[8*b+7];
      r[8*b+2] = w[8*b+6];
      r[8*b+4] = w[8*b+5];
      r[8*b+6] = w[8*b+4];
      r[8*b+1] = w[8*b+3];
      r[8*b+3] = w[8*b+2];
      r[8*b+5] = w[8*b+1];
      r[8*b+7] = w[8*b+0];
    end
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [31:0] data);
    in_valid = valid;
    in_data  = data;
  endtask

  task automatic nextCycle;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rstn = 1'b0;
    applyStimulus(1'b0, 32'h0);
`ifdef TX_MAP_PRBS_EN
    prbs_mode = 1'b0;
`endif
    #12;
    checkOutput("rst_tx_data", tx_data, TRAIN_M);
    checkOutput("rst_tx_ctrl", 32'(tx_ctrl), 32'd1);
    checkOutput("rst_tx_train", 32'(tx_train), 32'd1);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd0);

    #10 rstn = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) nextCycle();
      checkOutput("train_data", tx_data, TRAIN_M);
      checkOutput("train_flag", 32'(tx_train), 32'd1);
      checkOutput("train_ready", 32'(in_ready), 32'd0);
    end

    nextCycle();
    slot = 0;
    checkOutput("run0_train", 32'(tx_train), 32'd0);
    checkOutput("run0_ready", 32'(in_ready), 32'd1);
    checkOutput("run0_idle", tx_data, IDLE_M);

    applyStimulus(1'b1, 32'h0102_0408);
    nextCycle();
    slot = 1;
    checkOutput("lat_idle", tx_data, IDLE_M);
    applyStimulus(1'b0, 32'h0);
    nextCycle();
    slot = 2;
    checkOutput("map_word", tx_data, 32'h8008_4004);
    checkOutput("map_ctrl", 32'(tx_ctrl), 32'd0);
    checkOutput("map_reorder", rxReorder(tx_data), 32'h0102_0408);

    for (int i = 0; i < 5; i++) begin
      nextCycle();
      slot = slot + 1;
      if (slot == 7) checkOutput("idle_sync", tx_data, SYNC_M);
      else checkOutput("idle_word", tx_data, IDLE_M);
      checkOutput("idle_ctrl", 32'(tx_ctrl), 32'd1);
      checkOutput("idle_ready", 32'(in_ready), 32'd1);
    end

    nextData   = 32'h100;
    expPayload = 32'h100;
    applyStimulus(1'b1, nextData);
    for (int i = 0; i < 24; i++) begin
      accepted = in_valid && in_ready;
      nextCycle();
      slot = (slot + 1) % 8;
      if (accepted) begin
        nextData = nextData + 1;
        applyStimulus(1'b1, nextData);
      end
      if (slot == 7) begin
        checkOutput("stream_sync", tx_data, SYNC_M);
        checkOutput("stream_sync_ctrl", 32'(tx_ctrl), 32'd1);
        checkOutput("stream_sync_ready", 32'(in_ready), 32'd0);
      end else if (i == 0) begin
        checkOutput("stream_first_idle", tx_data, IDLE_M);
      end else begin
        checkOutput("stream_ctrl", 32'(tx_ctrl), 32'd0);
        checkOutput("stream_payload", rxReorder(tx_data), expPayload);
        expPayload = expPayload + 1;
      end
    end

    #2 rstn = 1'b0;
    applyStimulus(1'b0, 32'h0);
    #1;
    checkOutput("midrst_tx_data", tx_data, TRAIN_M);
    checkOutput("midrst_tx_ctrl", 32'(tx_ctrl), 32'd1);
    checkOutput("midrst_tx_train", 32'(tx_train), 32'd1);
    checkOutput("midrst_in_ready", 32'(in_ready), 32'd0);
    nextCycle();
    nextCycle();
    #3 rstn = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) nextCycle();
      checkOutput("retrain_data", tx_data, TRAIN_M);
      checkOutput("retrain_flag", 32'(tx_train), 32'd1);
    end
    for (int i = 0; i < 6; i++) begin
      nextCycle();
      checkOutput("post_rst_idle", tx_data, IDLE_M);
      checkOutput("post_rst_ctrl", 32'(tx_ctrl), 32'd1);
    end
    slot = 5;

`ifdef TX_MAP_PRBS_EN
    prbs_mode = 1'b1;
    applyStimulus(1'b1, 32'hDEAD_0000);
    #1;
    checkOutput("prbs_ready", 32'(in_ready), 32'd0);
    refLfsr = 7'h7F;
    for (int i = 0; i < 6; i++) begin
      nextCycle();
      slot = (slot + 1) % 8;
      if (slot == 7) begin
        checkOutput("prbs_sync", tx_data, SYNC_M);
      end else begin
        for (int k = 0; k < 32; k++) begin
          refWord[31 - k] = refLfsr[6] ^ refLfsr[5];
          refLfsr = {refLfsr[5:0], refLfsr[6] ^ refLfsr[5]};
        end
        checkOutput("prbs_ctrl", 32'(tx_ctrl), 32'd0);
        checkOutput("prbs_word", rxReorder(tx_data), refWord);
      end
      checkOutput("prbs_ready_run", 32'(in_ready), 32'd0);
    end
    prbs_mode = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
